// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Holds access-size encoding, responder FSM states and alignment helpers.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_RESP = 2'b10
  } resp_state_e;

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] addr_lo
  );
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = |addr_lo;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] lane_en(
    input logic [1:0] size,
    input logic [1:0] addr_lo
  );
    logic [3:0] be;
    be = 4'b1111;
    case (size)
      SZ_BYTE: be = 4'b0001 << addr_lo;
      SZ_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/load_align.sv
// Load alignment: picks the byte/half addressed within a RAM word and extends it.
// Ports: word_i (RAM word), addr_lo_i, size_i, unsigned_i in; data_o out.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sgn;

  always_comb begin
    byte_sel = word_i[7:0];
    case (addr_lo_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
  end

  assign half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

  always_comb begin
    sgn    = 1'b0;
    data_o = word_i;
    case (size_i)
      SZ_BYTE: begin
        sgn    = ~unsigned_i & byte_sel[7];
        data_o = {{24{sgn}}, byte_sel};
      end
      SZ_HALF: begin
        sgn    = ~unsigned_i & half_sel[15];
        data_o = {{16{sgn}}, half_sel};
      end
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, stores commit at accept,
// loads/errors answered after LATENCY wait states.
// Ports: clk, reset; req_valid/ready/we/size/unsigned/addr/wdata in;
// rsp_valid/rdata/err out, rsp_ready in.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_M1 =
    (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  resp_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic [IW-1:0] idx_q;
  logic [1:0]    lo_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic          we_q;
  logic          err_q;

  logic [31:0] rdata_q, rdata_d;
  logic        rerr_q, rerr_d;

  logic [3:0][7:0] ram_q [DEPTH_WORDS];

  logic          accept;
  logic          req_err;
  logic [IW-1:0] req_idx;
  logic [3:0]    be;
  logic [3:0][7:0] wr_lanes;
  logic          wr_en;

  logic          in_idle;
  logic          enter_resp;
  logic [IW-1:0] cur_idx;
  logic [1:0]    cur_lo;
  logic [1:0]    cur_size;
  logic          cur_uns;
  logic          cur_we;
  logic          cur_err;
  logic [31:0]   rd_word;
  logic [31:0]   ld_data;

  assign in_idle   = (state_q == S_IDLE);
  assign req_ready = in_idle & ~reset;
  assign accept    = req_valid & req_ready;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = rerr_q;

  assign req_idx = req_addr[IW+1:2];
  assign req_err = (req_size == 2'b11)
                 | misaligned(req_size, req_addr[1:0])
                 | (req_addr[31:2] >= 30'(DEPTH_WORDS));
  assign be      = lane_en(req_size, req_addr[1:0]);
  assign wr_en   = accept & req_we & ~req_err;

  always_comb begin
    wr_lanes = req_wdata;
    case (req_size)
      SZ_BYTE: wr_lanes = {4{req_wdata[7:0]}};
      SZ_HALF: wr_lanes = {2{req_wdata[15:0]}};
      default: wr_lanes = req_wdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int l = 0; l < 4; l++) begin
        if (be[l]) ram_q[req_idx][l] <= wr_lanes[l];
      end
    end
  end

  // With LATENCY 0 the response is built on the accept edge itself,
  // before the request fields have been latched, so read from the inputs.
  assign cur_idx  = in_idle ? req_idx       : idx_q;
  assign cur_lo   = in_idle ? req_addr[1:0] : lo_q;
  assign cur_size = in_idle ? req_size      : size_q;
  assign cur_uns  = in_idle ? req_unsigned  : uns_q;
  assign cur_we   = in_idle ? req_we        : we_q;
  assign cur_err  = in_idle ? req_err       : err_q;

  assign rd_word = ram_q[cur_idx];

  load_align u_align (
    .word_i     (rd_word),
    .addr_lo_i  (cur_lo),
    .size_i     (cur_size),
    .unsigned_i (cur_uns),
    .data_o     (ld_data)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    rdata_d    = rdata_q;
    rerr_d     = rerr_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (enter_resp) begin
      rerr_d  = cur_err;
      rdata_d = (cur_err | cur_we) ? 32'd0 : ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      rerr_q  <= 1'b0;
      idx_q   <= '0;
      lo_q    <= 2'd0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
      if (accept) begin
        idx_q  <= req_idx;
        lo_q   <= req_addr[1:0];
        size_q <= req_size;
        uns_q  <= req_unsigned;
        we_q   <= req_we;
        err_q  <= req_err;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY 1, 0 and 3 instances.
// Slot 0 = LATENCY 1 (1024 words), slot 1 = LATENCY 0, slot 2 = LATENCY 3.
module tb_dmem_responder;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  vld;
  logic [2:0]  rdy;
  logic        we;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] addr;
  logic [31:0] wdata;

  wire [2:0]   qrdy;
  wire [2:0]   svld;
  wire [2:0]   serr;
  wire [31:0]  sdat [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u1 (
    .clk(clk), .reset(reset),
    .req_valid(vld[0]), .req_ready(qrdy[0]),
    .req_we(we), .req_size(size), .req_unsigned(uns),
    .req_addr(addr), .req_wdata(wdata),
    .rsp_valid(svld[0]), .rsp_ready(rdy[0]),
    .rsp_rdata(sdat[0]), .rsp_err(serr[0])
  );

  dmem_responder #(.DEPTH_WORDS(16), .LATENCY(0)) u0 (
    .clk(clk), .reset(reset),
    .req_valid(vld[1]), .req_ready(qrdy[1]),
    .req_we(we), .req_size(size), .req_unsigned(uns),
    .req_addr(addr), .req_wdata(wdata),
    .rsp_valid(svld[1]), .rsp_ready(rdy[1]),
    .rsp_rdata(sdat[1]), .rsp_err(serr[1])
  );

  dmem_responder #(.DEPTH_WORDS(16), .LATENCY(3)) u3 (
    .clk(clk), .reset(reset),
    .req_valid(vld[2]), .req_ready(qrdy[2]),
    .req_we(we), .req_size(size), .req_unsigned(uns),
    .req_addr(addr), .req_wdata(wdata),
    .rsp_valid(svld[2]), .rsp_ready(rdy[2]),
    .rsp_rdata(sdat[2]), .rsp_err(serr[2])
  );

  task automatic issue(
    input int k, input logic w, input logic [1:0] sz,
    input logic u, input logic [31:0] a, input logic [31:0] d,
    output int lat
  );
    int n;
    @(negedge clk);
    we = w; size = sz; uns = u; addr = a; wdata = d;
    vld[k] = 1'b1;
    n = 0;
    while (!qrdy[k] && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    vld[k] = 1'b0;
    lat = 1;
    while (!svld[k] && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic txn(
    input int k, input logic w, input logic [1:0] sz,
    input logic u, input logic [31:0] a, input logic [31:0] d,
    output logic [31:0] rd, output logic er, output int lat
  );
    rdy[k] = 1'b1;
    issue(k, w, sz, u, a, d, lat);
    rd = sdat[k];
    er = serr[k];
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rsp(
    input string nm, input logic [31:0] rd, input logic er,
    input int lat, input logic [31:0] xrd, input logic xer,
    input int xlat
  );
    checks++;
    if (rd !== xrd || er !== xer || lat != xlat) begin
      errors++;
      $display("FAIL %s: got rdata=%h err=%b lat=%0d want rdata=%h err=%b lat=%0d",
               nm, rd, er, lat, xrd, xer, xlat);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    vld = 3'b000;
    rdy = 3'b000;
    we = 1'b0; size = 2'b00; uns = 1'b0;
    addr = 32'd0; wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (qrdy !== 3'b000 || svld !== 3'b000 || serr !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctl: got qrdy=%b svld=%b serr=%b want 000 000 000",
               qrdy, svld, serr);
    end
    checks++;
    if (sdat[0] !== 32'd0 || sdat[2] !== 32'd0) begin
      errors++;
      $display("FAIL reset_rdata: got %h/%h want 0", sdat[0], sdat[2]);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (qrdy !== 3'b111) begin
      errors++;
      $display("FAIL reset_release: got qrdy=%b want 111", qrdy);
    end
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat;
    txn(0, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat);
    expect_rsp("word_store", rd, er, lat, 32'h0, 1'b0, 2);
    txn(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, rd, er, lat);
    expect_rsp("word_load", rd, er, lat, 32'hDEADBEEF, 1'b0, 2);
  endtask

  task automatic test_byte();
    logic [31:0] rd; logic er; int lat;
    txn(0, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'h0, rd, er, lat);
    txn(0, 1'b1, SZ_BYTE, 1'b0, 32'h13, 32'h12345680, rd, er, lat);
    expect_rsp("byte_store", rd, er, lat, 32'h0, 1'b0, 2);
    txn(0, 1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0, rd, er, lat);
    expect_rsp("byte_signed", rd, er, lat, 32'hFFFFFF80, 1'b0, 2);
    txn(0, 1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0, rd, er, lat);
    expect_rsp("byte_unsigned", rd, er, lat, 32'h00000080, 1'b0, 2);
    txn(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, rd, er, lat);
    expect_rsp("byte_word", rd, er, lat, 32'h80000000, 1'b0, 2);
  endtask

  task automatic test_half();
    logic [31:0] rd; logic er; int lat;
    txn(0, 1'b1, SZ_WORD, 1'b0, 32'h20, 32'h0, rd, er, lat);
    txn(0, 1'b1, SZ_HALF, 1'b0, 32'h22, 32'hABCD8001, rd, er, lat);
    txn(0, 1'b0, SZ_HALF, 1'b0, 32'h22, 32'h0, rd, er, lat);
    expect_rsp("half_signed", rd, er, lat, 32'hFFFF8001, 1'b0, 2);
    txn(0, 1'b0, SZ_HALF, 1'b1, 32'h22, 32'h0, rd, er, lat);
    expect_rsp("half_unsigned", rd, er, lat, 32'h00008001, 1'b0, 2);
    txn(0, 1'b0, SZ_HALF, 1'b0, 32'h21, 32'h0, rd, er, lat);
    expect_rsp("half_misalign", rd, er, lat, 32'h0, 1'b1, 2);
    txn(0, 1'b1, SZ_HALF, 1'b0, 32'h21, 32'hFFFF, rd, er, lat);
    expect_rsp("half_st_misalign", rd, er, lat, 32'h0, 1'b1, 2);
    txn(0, 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, rd, er, lat);
    expect_rsp("half_word", rd, er, lat, 32'h80010000, 1'b0, 2);
    txn(0, 1'b0, SZ_BYTE, 1'b0, 32'h23, 32'h0, rd, er, lat);
    expect_rsp("byte_lane3", rd, er, lat, 32'hFFFFFF80, 1'b0, 2);
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    txn(0, 1'b1, SZ_WORD, 1'b0, 32'h0, 32'h0, rd, er, lat);
    txn(0, 1'b1, SZ_WORD, 1'b0, 32'h1002, 32'hFFFFFFFF, rd, er, lat);
    expect_rsp("err_st_1002", rd, er, lat, 32'h0, 1'b1, 2);
    txn(0, 1'b1, SZ_WORD, 1'b0, 32'h1000, 32'hFFFFFFFF, rd, er, lat);
    expect_rsp("err_st_range", rd, er, lat, 32'h0, 1'b1, 2);
    txn(0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, rd, er, lat);
    expect_rsp("err_no_write", rd, er, lat, 32'h0, 1'b0, 2);
    txn(0, 1'b0, SZ_WORD, 1'b0, 32'h1000, 32'h0, rd, er, lat);
    expect_rsp("err_ld_range", rd, er, lat, 32'h0, 1'b1, 2);
    txn(0, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, rd, er, lat);
    expect_rsp("err_size11", rd, er, lat, 32'h0, 1'b1, 2);
  endtask

  task automatic test_backpressure(input int k, input int xlat);
    logic [31:0] rd; logic er; int lat;
    logic [31:0] xd;
    xd = 32'hCAFE0000 | 32'(k);
    txn(k, 1'b1, SZ_WORD, 1'b0, 32'h4, xd, rd, er, lat);
    rdy[k] = 1'b0;
    issue(k, 1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0, lat);
    expect_rsp($sformatf("bp_first_%0d", k), sdat[k], serr[k],
               lat, xd, 1'b0, xlat);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (svld[k] !== 1'b1 || sdat[k] !== xd ||
          serr[k] !== 1'b0 || qrdy[k] !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d: got v=%b d=%h e=%b qr=%b want v=1 d=%h e=0 qr=0",
                 k, svld[k], sdat[k], serr[k], qrdy[k], xd);
      end
    end
    @(negedge clk);
    rdy[k] = 1'b1;
    #1;
    checks++;
    if (qrdy[k] !== 1'b0) begin
      errors++;
      $display("FAIL bp_take_cycle_%0d: got qrdy=%b want 0", k, qrdy[k]);
    end
    @(posedge clk);
    #1;
    checks++;
    if (qrdy[k] !== 1'b1 || svld[k] !== 1'b0) begin
      errors++;
      $display("FAIL bp_after_%0d: got qrdy=%b svld=%b want 1 0",
               k, qrdy[k], svld[k]);
    end
  endtask

  task automatic test_back_to_back();
    int acc;
    acc = 0;
    rdy[0] = 1'b1;
    @(negedge clk);
    we = 1'b0; size = SZ_WORD; uns = 1'b0; addr = 32'h10;
    vld[0] = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (qrdy[0]) acc++;
      @(negedge clk);
    end
    vld[0] = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (acc != 4) begin
      errors++;
      $display("FAIL back_to_back: got %0d accepts want 4", acc);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat;
    int seen;
    rdy[2] = 1'b1;
    @(negedge clk);
    we = 1'b0; size = SZ_WORD; uns = 1'b0; addr = 32'h4;
    vld[2] = 1'b1;
    @(posedge clk);
    #1;
    vld[2] = 1'b0;
    @(negedge clk);
    checks++;
    if (u3.state_q !== S_WAIT) begin
      errors++;
      $display("FAIL mid_in_wait: got state=%0d want %0d", u3.state_q, S_WAIT);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (svld[2] !== 1'b0 || qrdy[2] !== 1'b0 || u3.state_q !== S_IDLE) begin
      errors++;
      $display("FAIL mid_reset: got svld=%b qrdy=%b state=%0d want 0 0 %0d",
               svld[2], qrdy[2], u3.state_q, S_IDLE);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (qrdy[2] !== 1'b1) begin
      errors++;
      $display("FAIL mid_release: got qrdy=%b want 1", qrdy[2]);
    end
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      if (svld[2]) seen++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL mid_aborted: got %0d rsp cycles want 0", seen);
    end
    txn(2, 1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0, rd, er, lat);
    expect_rsp("mid_reload", rd, er, lat, 32'hCAFE0002, 1'b0, 4);
    txn(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, rd, er, lat);
    expect_rsp("mid_ram_kept", rd, er, lat, 32'h80000000, 1'b0, 2);
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_backpressure(0, 2);
    test_backpressure(1, 1);
    test_backpressure(2, 4);
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder: the target end of the core's load/store port. Accepts one request at a time over a valid/ready handshake, performs byte/half/word stores with lane enables and loads with sign or zero extension, and returns a registered response after a configurable number of wait states. It sits between the core's memory-access stage and a word-organised on-chip RAM, replacing the zero-latency combinational data memory.

## Interface

- `DEPTH_WORDS`, 1024: RAM depth in 32-bit words. Power of two.
- `LATENCY`, 1: wait states between accept and response, 0..15.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned`  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  requester takes the response.
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors.
- `rsp_err`  out  1  request was misaligned, out of range or illegal size.

## Operation

- FSM states are IDLE, WAIT and RESP.
- `req_ready` = 1 only in IDLE and never while `reset` is high.
- **Accept** happens on `req_valid && req_ready`. On the accept edge:
  - Address, size, unsigned flag and error status are latched.
  - A legal store writes the RAM on that same edge.
- **Error conditions**, any of which sets the error flag:
  - `req_size` = 11.
  - Half access with `addr[0]` = 1.
  - Word access with `addr[1:0]` ≠ 00.
  - Word index `addr[31:2]` ≥ `DEPTH_WORDS`.
- An errored request performs no RAM write and still gets a response.
- **Store lanes**:
  - Byte: lane `addr[1:0]`, data `wdata[7:0]` replicated across lanes.
  - Half: lanes {`addr[1]`*2+1, `addr[1]`*2}, data `wdata[15:0]` replicated.
  - Word: all four lanes.
- **Load**:
  - Read the word, select the byte/half at `addr[1:0]`.
  - Extend to 32 bits per the latched `req_unsigned`.
  - Register the result into `rsp_rdata` on entry to RESP.
- **Transitions**:
  - IDLE→WAIT on accept if `LATENCY` > 0, else IDLE→RESP.
  - In WAIT, a counter loaded with `LATENCY`-1 decrements each cycle; WAIT→RESP when it reaches 0.
  - RESP→IDLE on `rsp_ready`; `rsp_valid`, `rsp_rdata` and `rsp_err` hold stable until then.
- No request can be accepted in the cycle the response is taken. `req_ready` rises the following cycle.
- Reset in any state forces IDLE, aborts any pending load, and drops `rsp_valid`. A store already accepted stays written.

## Timing

- Reset values: state IDLE, `req_ready` 0 during reset and 1 the cycle after, `rsp_valid` 0, `rsp_rdata` 0, `rsp_err` 0, wait counter 0.
- RAM contents are not reset.
- Latency: `rsp_valid` rises `LATENCY`+1 cycles after the accept edge.
- Throughput with `rsp_ready` tied high: one request per `LATENCY`+2 cycles.
- A load following a store to the same address returns the new data, because the write commits at accept.
- `rsp_ready` asserted outside RESP is ignored.

## Structure

- Package `mem_pkg` holds:
  - `mem_size_e` {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10}.
  - FSM enum `resp_state_e`.
  - Function `misaligned(size, addr_lo)`.
- Sub-module `load_align`: combinational word + `addr[1:0]` + size + unsigned → 32-bit extended data.
- RAM is an inferred array of 4 × 8-bit lanes with a per-lane write enable.

## Test plan

- **Word store then load.** `LATENCY`=1. Store word 0xDEADBEEF @0x10, then load word @0x10 → first `rsp_valid` 2 cycles after accept with `rsp_rdata`=0; second returns `rsp_rdata`=0xDEADBEEF, `rsp_err`=0.
- **Byte store and extension.** Store byte 0x80 @0x13 over 0x00000000, then:
  - Signed byte load @0x13 → 0xFFFFFF80.
  - Unsigned byte load @0x13 → 0x00000080.
  - Word load @0x10 → 0x80000000.
- **Half access.** Store half 0x8001 @0x22, then signed half load @0x22 → 0xFFFF8001. Half load @0x21 → `rsp_err`=1, `rsp_rdata`=0, and word 0x20 is unchanged.
- **Error cases.** Word store @0x1002 → `rsp_err`=1 with no write. Word load @(`DEPTH_WORDS`*4) → `rsp_err`=1. `req_size`=11 → `rsp_err`=1.
- **Backpressure.** Hold `rsp_ready`=0 for 5 cycles → response fields stable and `req_ready`=0 throughout. `req_ready` returns 1 the cycle after `rsp_ready` goes high. Repeat with `LATENCY`=0 (response 1 cycle after accept) and `LATENCY`=3 (4 cycles).
- **Reset mid-operation.** Assert `reset` while in WAIT → next cycle `rsp_valid`=0 and state IDLE. After release, `req_ready`=1 and a new load returns the correct data.
